zero_lane_count_pipe: RTL and testbench
=======================================

# zero_lane_count_pipe

Streaming, parametrised successor to the combinational 32-bit zero-byte counter in the FHE benchmark set. Splits each DATA_W-bit input word into LANES lanes of LANE_W bits and counts the all-zero lanes. Counts either per word or summed over a frame, through a 2-stage pipeline with valid/ready handshakes on both sides. It sits between a word-stream producer and the statistics/compare logic downstream.

## Interface
- DATA_W, 32, input word width; must be a multiple of LANE_W
- LANE_W, 8, lane width in bits
- LANES, DATA_W/LANE_W, derived; not overridable
- CNT_W, $clog2(LANES+1), width of one word's count
- ACC_W, 16, accumulator/output width; must be ≥ CNT_W
- Reset: one clock; reset is synchronous and active-high.
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_data  in  DATA_W  word; lane k = in_data[k*LANE_W +: LANE_W]
- in_last  in  1  last beat of frame (used only when in_mode=1)
- in_mode  in  1  0 = per-word count, 1 = frame accumulate; travels with the beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_count  out  ACC_W  zero-lane count, zero-extended
- out_sat  out  1  frame sum saturated (always 0 for mode-0 results)

## Operation
- Accept: a beat transfers when in_valid && in_ready at a rising edge.
- Stage 1 registers the beat's lane-zero vector (LANES bits, bit k = lane k == 0), mode, last and a valid bit.
- Stage 2 popcounts the vector to CNT_W bits and applies the mode:
  - mode 0: emit count; the accumulator is untouched.
  - mode 1, last=0: acc ← sat_add(acc, count). No output. Stage 2 does not hold valid.
  - mode 1, last=1: emit sat_add(acc, count); acc ← 0; sat flag ← 0.
- sat_add clamps at 2^ACC_W−1. When a clamp occurs, a sticky sat flag is set. out_sat is the sticky flag OR a clamp on the final add.
- Mode-0 beats in the middle of a mode-1 frame are legal. They emit their own count and leave the partial frame sum intact.
- Pipeline control is stall-all: en = !out_valid || out_ready, and in_ready = en. Both stages advance only when en=1. Bubbles move through like data.
- The output register holds out_count/out_sat stable while out_valid && !out_ready.
- Reset: stage valids 0, out_valid 0, out_count 0, out_sat 0, acc 0, sticky sat 0. in_ready is 1 in the cycle after reset deasserts. A reset mid-frame discards the partial sum and any in-flight beats; no output is produced for them.

## Timing
- Latency: a beat accepted at edge T has its result visible (out_valid=1) after edge T+2, provided no stall occurs.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: a result held with out_ready=0 drops in_ready in the same cycle. No beats are lost or duplicated. Ordering is strictly preserved.
- Simultaneous out accept and in accept in one cycle is legal. The pipeline shifts by one.
- Mode-1 non-last beats never raise out_valid. A frame of N beats produces exactly one result, 2 cycles after its last beat is accepted (absent stalls).
- in_ready depends combinationally on out_ready and out_valid only. It does not depend on in_valid.

## Test plan
- Per-word, DATA_W=32, LANE_W=8, out_ready=1, mode 0:
  - Beats 0x00000000, 0x00FF0000, 0x01010101, 0x80000001 → out_count 4, 3, 0, 2.
  - Results appear on consecutive cycles starting 2 cycles after the first accept.
  - out_sat=0 throughout.
- Frame, mode 1:
  - Beats 0x00000000, 0x12003400, 0xFFFFFFFF (last) → exactly one result, out_count 6, out_sat 0, 2 cycles after the last beat.
  - A following frame of 0x00000000 (last) → 4, which confirms acc was cleared.
- Saturation, ACC_W=3 (LANES=4):
  - Frame 0x00000000, 0x00000000 (last) → out_count 7, out_sat 1.
  - A next frame 0xFF00FFFF (last) → 1, out_sat 0.
- Backpressure:
  - Stream 8 mode-0 beats while out_ready toggles 1,0,0,1,...
  - Required: in_ready low exactly when out_valid && !out_ready. out_count is stable while stalled. All 8 counts arrive in order with none dropped or duplicated.
- Interleave and reset:
  - A mode-1 beat 0x00000000, then a mode-0 beat 0x0000FFFF (→ 2 emitted), then mode-1 0x00FFFFFF (last) → 5.
  - Separately, assert rst for 1 cycle after 2 beats of a mode-1 frame. Then send 0xFFFF00FF (last) → 1, with no spurious output during or after reset.
  - All outputs read 0 in the cycle after reset.

Source files
------------

// File: rtl/zero_lane_count_pipe_if.sv
// Handshake bundle for zero_lane_count_pipe: a word-stream input side and
// a count-result output side, each with its own valid/ready pair.
interface zero_lane_count_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_count;
  logic              out_sat;

  // Producer/consumer side: drives the input beat and accepts results
  modport master (
    output in_valid, in_data, in_last, in_mode, out_ready,
    input  in_ready, out_valid, out_count, out_sat
  );

  // Block side: accepts beats and drives results
  modport slave (
    input  in_valid, in_data, in_last, in_mode, out_ready,
    output in_ready, out_valid, out_count, out_sat
  );
endinterface

// File: rtl/zero_lane_count_pipe.sv
// Streaming zero-lane counter. Each DATA_W-bit word is split into LANES
// lanes of LANE_W bits and the all-zero lanes are counted, either per word
// (mode 0) or summed with saturation over a frame (mode 1).
// Pipeline: stage 1 holds the lane-zero vector, stage 2 holds its popcount,
// and the output stage applies the mode and owns the frame accumulator.
// All stages advance together (stall-all) whenever the output can move.
module zero_lane_count_pipe #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8,
  parameter int ACC_W  = 16
) (
  input logic clk,
  input logic rst,
  zero_lane_count_pipe_if.slave bus
);
  localparam int LANES = DATA_W / LANE_W;
  localparam int CNT_W = $clog2(LANES + 1);

  // Number of set bits in a lane-zero vector
  function automatic logic [CNT_W-1:0] f_popcount(input logic [LANES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int k = 0; k < LANES; k++) begin
      c = c + CNT_W'(v[k]);
    end
    return c;
  endfunction

  // Saturating add; MSB of the result flags that a clamp happened
  function automatic logic [ACC_W:0] f_sat_add(input logic [ACC_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W + 1)'(b);
    if (s[ACC_W]) begin
      s = {1'b1, {ACC_W{1'b1}}};
    end
    return s;
  endfunction

  logic              w_en;
  logic [LANES-1:0]  w_zero_vec;
  logic [ACC_W:0]    w_add;
  logic [ACC_W-1:0]  w_add_sum;
  logic              w_add_clamp;

  logic              r_s1_valid;
  logic [LANES-1:0]  r_s1_zero;
  logic              r_s1_mode;
  logic              r_s1_last;
  logic              r_s2_valid;
  logic [CNT_W-1:0]  r_s2_cnt;
  logic              r_s2_mode;
  logic              r_s2_last;
  logic              r_out_valid;
  logic [ACC_W-1:0]  r_out_count;
  logic              r_out_sat;
  logic [ACC_W-1:0]  r_acc;
  logic              r_sticky;

  // Whole pipe advances unless a result is being held for the consumer
  assign w_en          = !r_out_valid || bus.out_ready;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_out_valid;
  assign bus.out_count = r_out_count;
  assign bus.out_sat   = r_out_sat;

  // Flag each input lane that is entirely zero
  always_comb begin
    w_zero_vec = '0;
    for (int k = 0; k < LANES; k++) begin
      w_zero_vec[k] = (bus.in_data[k*LANE_W +: LANE_W] == {LANE_W{1'b0}});
    end
  end

  // Frame sum including the word currently in stage 2
  assign w_add       = f_sat_add(r_acc, r_s2_cnt);
  assign w_add_clamp = w_add[ACC_W];
  assign w_add_sum   = w_add[ACC_W-1:0];

  // Stage 1: capture lane-zero vector and sideband; a missing beat becomes a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_zero  <= '0;
      r_s1_mode  <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= bus.in_valid;
      r_s1_zero  <= w_zero_vec;
      r_s1_mode  <= bus.in_mode;
      r_s1_last  <= bus.in_last;
    end
  end

  // Stage 2: reduce the lane-zero vector to a per-word count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_cnt   <= '0;
      r_s2_mode  <= 1'b0;
      r_s2_last  <= 1'b0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_cnt   <= f_popcount(r_s1_zero);
      r_s2_mode  <= r_s1_mode;
      r_s2_last  <= r_s1_last;
    end
  end

  // Output stage: emit per-word counts, accumulate frames, hold result while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
      r_acc       <= '0;
      r_sticky    <= 1'b0;
    end else if (w_en) begin
      if (r_s2_valid) begin
        if (!r_s2_mode) begin
          // Per-word result; a partial frame sum stays untouched
          r_out_valid <= 1'b1;
          r_out_count <= ACC_W'(r_s2_cnt);
          r_out_sat   <= 1'b0;
        end else if (!r_s2_last) begin
          // Mid-frame beat: fold into the sum, produce nothing
          r_out_valid <= 1'b0;
          r_acc       <= w_add_sum;
          r_sticky    <= r_sticky | w_add_clamp;
        end else begin
          // Frame end: emit the sum and start the next frame from zero
          r_out_valid <= 1'b1;
          r_out_count <= w_add_sum;
          r_out_sat   <= r_sticky | w_add_clamp;
          r_acc       <= '0;
          r_sticky    <= 1'b0;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_zero_lane_count_pipe.sv
// Self-checking bench for zero_lane_count_pipe. Two instances (ACC_W=16 and
// ACC_W=3) receive identical stimulus; a behavioural model predicts both.
module tb_zero_lane_count_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        drv_valid;
  logic [31:0] drv_data;
  logic        drv_last;
  logic        drv_mode;
  logic        drv_ordy;
  int          or_mode;   // 0 fixed, 1 pattern 1,0,0, 2 random
  int          or_cyc;
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_out   = 0;

  always #5 clk = ~clk;

  zero_lane_count_pipe_if #(.DATA_W(32), .ACC_W(16)) ifa ();
  zero_lane_count_pipe_if #(.DATA_W(32), .ACC_W(3))  ifb ();

  assign ifa.in_valid  = drv_valid;
  assign ifa.in_data   = drv_data;
  assign ifa.in_last   = drv_last;
  assign ifa.in_mode   = drv_mode;
  assign ifa.out_ready = drv_ordy;
  assign ifb.in_valid  = drv_valid;
  assign ifb.in_data   = drv_data;
  assign ifb.in_last   = drv_last;
  assign ifb.in_mode   = drv_mode;
  assign ifb.out_ready = drv_ordy;

  zero_lane_count_pipe #(.DATA_W(32), .LANE_W(8), .ACC_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  zero_lane_count_pipe #(.DATA_W(32), .LANE_W(8), .ACC_W(3)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  typedef struct {
    int c16;
    bit s16;
    int c3;
    bit s3;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [31:0] d;
    logic        m;
    logic        l;
    logic        emit;
    int          c16;
    logic        s16;
    int          c3;
    logic        s3;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Count zero bytes with plain arithmetic
  function automatic int zero_lanes(input logic [31:0] d);
    int n;
    n = 0;
    for (int k = 0; k < 4; k++) if (((d >> (8 * k)) & 32'hFF) == 32'h0) n++;
    return n;
  endfunction

  // Reference model and output monitor, evaluated between clock edges
  initial begin : monitor
    int  acc16, acc3, s16, s3, c;
    bit  st16, st3, cl16, cl3, hold;
    int  p16, p3, ps16, ps3;
    exp_t e;
    acc16 = 0; acc3 = 0; st16 = 0; st3 = 0; hold = 0;
    p16 = 0; p3 = 0; ps16 = 0; ps3 = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        acc16 = 0; acc3 = 0; st16 = 0; st3 = 0; hold = 0;
      end else begin
        chk("in_ready_a", int'(ifa.in_ready), int'(!(ifa.out_valid && !drv_ordy)));
        chk("in_ready_b", int'(ifb.in_ready), int'(!(ifa.out_valid && !drv_ordy)));
        chk("valid_lockstep", int'(ifb.out_valid), int'(ifa.out_valid));
        if (hold) begin
          chk("stall_count_a", int'(ifa.out_count), p16);
          chk("stall_count_b", int'(ifb.out_count), p3);
          chk("stall_sat_a", int'(ifa.out_sat), ps16);
          chk("stall_sat_b", int'(ifb.out_sat), ps3);
        end
        if (ifa.out_valid && drv_ordy) begin
          n_out++;
          chk("out_expected", int'(q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("count_a", int'(ifa.out_count), e.c16);
            chk("sat_a", int'(ifa.out_sat), int'(e.s16));
            chk("count_b", int'(ifb.out_count), e.c3);
            chk("sat_b", int'(ifb.out_sat), int'(e.s3));
          end
        end
        hold = ifa.out_valid && !drv_ordy;
        p16 = int'(ifa.out_count); p3 = int'(ifb.out_count);
        ps16 = int'(ifa.out_sat);  ps3 = int'(ifb.out_sat);
        if (drv_valid && ifa.in_ready) begin
          c = zero_lanes(drv_data);
          if (!drv_mode) begin
            q.push_back('{c, 1'b0, c, 1'b0});
          end else begin
            s16 = acc16 + c; cl16 = (s16 > 65535); if (cl16) s16 = 65535;
            s3  = acc3 + c;  cl3  = (s3 > 7);      if (cl3) s3 = 7;
            if (!drv_last) begin
              acc16 = s16; st16 = st16 | cl16;
              acc3  = s3;  st3  = st3 | cl3;
            end else begin
              q.push_back('{s16, st16 | cl16, s3, st3 | cl3});
              acc16 = 0; acc3 = 0; st16 = 0; st3 = 0;
            end
          end
        end
      end
    end
  end

  // Present one beat and hold it until accepted (bounded)
  task automatic send(input logic [31:0] d, input logic m, input logic l);
    int n;
    n = 0;
    drv_data = d; drv_mode = m; drv_last = l; drv_valid = 1'b1;
    @(negedge clk);
    while (!ifa.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", int'(n < 64), 1);
    @(posedge clk); #1;
    drv_valid = 1'b0;
  endtask

  // Return out_ready to 1 and wait for every predicted result to leave
  task automatic drain();
    int n;
    n = 0;
    or_mode = 0;
    @(posedge clk); #2;
    drv_ordy = 1'b1;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_valid_a"}, int'(ifa.out_valid), 0);
    chk({tag, "_count_a"}, int'(ifa.out_count), 0);
    chk({tag, "_sat_a"}, int'(ifa.out_sat), 0);
    chk({tag, "_ready_a"}, int'(ifa.in_ready), 1);
    chk({tag, "_valid_b"}, int'(ifb.out_valid), 0);
    chk({tag, "_count_b"}, int'(ifb.out_count), 0);
    chk({tag, "_sat_b"}, int'(ifb.out_sat), 0);
    chk({tag, "_ready_b"}, int'(ifb.in_ready), 1);
  endtask

  initial begin : stim
    int exp4[4];
    int n0;
    logic [31:0] d;
    tbl[0]  = '{32'h00000000, 1'b0, 1'b0, 1'b1, 4, 1'b0, 4, 1'b0};
    tbl[1]  = '{32'h00FF0000, 1'b0, 1'b0, 1'b1, 3, 1'b0, 3, 1'b0};
    tbl[2]  = '{32'h01010101, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 1'b0};
    tbl[3]  = '{32'h80000001, 1'b0, 1'b0, 1'b1, 2, 1'b0, 2, 1'b0};
    tbl[4]  = '{32'h00000000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[5]  = '{32'h12003400, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[6]  = '{32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 6, 1'b0, 6, 1'b0};
    tbl[7]  = '{32'h00000000, 1'b1, 1'b1, 1'b1, 4, 1'b0, 4, 1'b0};
    tbl[8]  = '{32'h00000000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[9]  = '{32'h00000000, 1'b1, 1'b1, 1'b1, 8, 1'b0, 7, 1'b1};
    tbl[10] = '{32'hFF00FFFF, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1, 1'b0};
    tbl[11] = '{32'h00000000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[12] = '{32'h0000FFFF, 1'b0, 1'b0, 1'b1, 2, 1'b0, 2, 1'b0};
    tbl[13] = '{32'h00FFFFFF, 1'b1, 1'b1, 1'b1, 5, 1'b0, 5, 1'b0};
    tbl[14] = '{32'h00000000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[15] = '{32'h00000000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[16] = '{32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 8, 1'b0, 7, 1'b1};

    rst = 1'b1; drv_valid = 1'b0; drv_data = 32'h0; drv_last = 1'b0;
    drv_mode = 1'b0; drv_ordy = 1'b1; or_mode = 0; or_cyc = 0;

    // out_ready generator for the backpressure and random phases
    fork
      forever begin
        @(posedge clk); #1;
        or_cyc++;
        if (or_mode == 1) drv_ordy = (or_cyc % 3 == 0);
        else if (or_mode == 2) drv_ordy = ($urandom_range(0, 3) != 0);
      end
    join_none

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_state("reset");
    @(posedge clk); #1;

    // Back-to-back mode-0 beats: results on consecutive cycles, 2 edges after accept
    exp4[0] = 4; exp4[1] = 3; exp4[2] = 0; exp4[3] = 2;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        drv_data = tbl[i].d; drv_mode = 1'b0; drv_last = 1'b0; drv_valid = 1'b1;
      end else begin
        drv_valid = 1'b0;
      end
      @(negedge clk);
      if (i == 2) chk("tput_early", int'(ifa.out_valid), 0);
      if (i >= 3) begin
        chk("tput_valid", int'(ifa.out_valid), 1);
        chk("tput_count", int'(ifa.out_count), exp4[i-3]);
        chk("tput_sat", int'(ifa.out_sat), 0);
      end
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;

    // Table: one beat at a time, checked at exact latency
    for (int i = 0; i < 17; i++) begin
      send(tbl[i].d, tbl[i].m, tbl[i].l);
      @(negedge clk);
      @(negedge clk);
      chk("tbl_latency", int'(ifa.out_valid), 0);
      @(negedge clk);
      chk("tbl_emit", int'(ifa.out_valid), int'(tbl[i].emit));
      if (tbl[i].emit) begin
        chk("tbl_count_a", int'(ifa.out_count), tbl[i].c16);
        chk("tbl_sat_a", int'(ifa.out_sat), int'(tbl[i].s16));
        chk("tbl_count_b", int'(ifb.out_count), tbl[i].c3);
        chk("tbl_sat_b", int'(ifb.out_sat), int'(tbl[i].s3));
      end
      @(posedge clk); #1;
    end

    // Backpressure: 8 mode-0 beats while out_ready follows 1,0,0
    n0 = n_out;
    or_cyc = 0; or_mode = 1;
    for (int i = 0; i < 8; i++) begin
      d = 32'hFFFFFFFF;
      for (int k = 0; k < (i % 5); k++) d[8*k +: 8] = 8'h00;
      send(d, 1'b0, 1'b0);
    end
    drain();
    chk("bp_results", n_out - n0, 8);

    // Reset in the middle of a frame with beats still in flight
    send(32'h00000000, 1'b1, 1'b0);
    send(32'h00000000, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_state("midreset");
    @(posedge clk); #1;
    send(32'hFFFF00FF, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("post_reset_early", int'(ifa.out_valid), 0);
    @(negedge clk);
    chk("post_reset_valid", int'(ifa.out_valid), 1);
    chk("post_reset_count_a", int'(ifa.out_count), 1);
    chk("post_reset_count_b", int'(ifb.out_count), 1);
    chk("post_reset_sat_b", int'(ifb.out_sat), 0);
    @(posedge clk); #1;

    // Random traffic against the model with random out_ready
    or_mode = 2;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      for (int k = 0; k < 4; k++)
        d[8*k +: 8] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      send(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 3));
    end
    send(32'h00000000, 1'b1, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
